multi_ring_tracer: RTL and testbench

Racing-the-beam distance engine that generalises the demo's single incremental circle tracer to `N_CH` independent centres. It produces the exact squared Euclidean distance from the current beam position to every centre, plus the nearest centre, with no per-pixel multiplier. It sits between the VGA timing generator and the per-effect colour logic, and consumes the generator's `hpos`/`vpos`. Centres are reloaded once per frame during vertical blanking by a shared sequential shift-add squarer.

---
 rtl/multi_ring_tracer.sv | 201 ++++++++++++++++++++
 tb/tb_multi_ring_tracer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ring_tracer.sv
// multi_ring_tracer: exact squared distance from the beam to N_CH centres using
// incremental (x-c)^2 accumulators, seeded each frame by a shared shift-add squarer.
module multi_ring_tracer #(
  parameter int N_CH     = 4,
  parameter int COORD_W  = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  localparam int DW      = 2 * COORD_W + 1,
  localparam int IDXW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COORD_W-1:0]      hpos,
  input  logic [COORD_W-1:0]      vpos,
  input  logic                    display_on,
  input  logic [N_CH*COORD_W-1:0] cx_in,
  input  logic [N_CH*COORD_W-1:0] cy_in,
  input  logic [N_CH-1:0]         ch_en,
  output logic [N_CH*DW-1:0]      dist2,
  output logic                    d2_valid,
  output logic [DW-1:0]           min_d2,
  output logic [IDXW-1:0]         min_idx,
  output logic                    min_valid,
  output logic                    ready,
  output logic                    busy
);

  if (2 * N_CH * (COORD_W + 1) + 2 > H_TOTAL || V_ACTIVE >= V_TOTAL) begin : g_param_check
    $error("multi_ring_tracer: squarer pass does not fit in one blanking line");
  end

  localparam int SW = $clog2(COORD_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQ_X = 2'd1;
  localparam logic [1:0] S_SQ_Y = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_EOL   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LATCH = COORD_W'(V_ACTIVE);

  logic [N_CH*COORD_W-1:0] sh_cx, sh_cy;
  logic [N_CH-1:0]         sh_en;

  logic [1:0]         state;
  logic [IDXW-1:0]    ch_q;
  logic [SW-1:0]      step_q;
  logic [COORD_W-1:0] sq_a, nxt_op;
  logic [DW-1:0]      sq_m, sq_acc;

  logic [DW-1:0]        col0_q  [N_CH];
  logic signed [DW:0]   row_q   [N_CH];
  logic signed [DW:0]   col_q   [N_CH];
  logic signed [DW:0]   row_inc [N_CH];
  logic signed [DW:0]   col_inc [N_CH];
  logic [DW-1:0]        sum     [N_CH];
  logic signed [COORD_W+1:0] dx, dy;

  logic          latch, eol, sq_wb, last_ch, pix, found;
  logic [DW-1:0]   best_d;
  logic [IDXW-1:0] best_i;

  assign latch   = (hpos == '0) && (vpos == V_LATCH);
  assign eol     = (hpos == H_EOL) && (vpos < V_LATCH);
  assign sq_wb   = (step_q == SW'(COORD_W));
  assign last_ch = (ch_q == IDXW'(N_CH - 1));
  assign pix     = ready && display_on;
  assign busy    = (state != S_IDLE);

  // Operand for the square after the current writeback; SQ_X rolls into cy[0].
  always_comb begin
    nxt_op = sh_cy[COORD_W-1:0];
    for (int unsigned k = 1; k < N_CH; k++) begin
      if (ch_q == IDXW'(k - 1))
        nxt_op = (state == S_SQ_X) ? sh_cx[k*COORD_W +: COORD_W] : sh_cy[k*COORD_W +: COORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_cx  <= '0;
      sh_cy  <= '0;
      sh_en  <= '0;
      state  <= S_IDLE;
      ch_q   <= '0;
      step_q <= '0;
      sq_a   <= '0;
      sq_m   <= '0;
      sq_acc <= '0;
      ready  <= 1'b0;
    end else begin
      if (latch) begin
        sh_cx <= cx_in;
        sh_cy <= cy_in;
        sh_en <= ch_en;
      end
      case (state)
        S_IDLE: begin
          if (latch) begin
            state  <= S_SQ_X;
            ch_q   <= '0;
            step_q <= '0;
            sq_a   <= cx_in[COORD_W-1:0];
            sq_m   <= {{(DW-COORD_W){1'b0}}, cx_in[COORD_W-1:0]};
            sq_acc <= '0;
          end
        end
        S_SQ_X, S_SQ_Y: begin
          if (!sq_wb) begin
            if (sq_a[0]) sq_acc <= sq_acc + sq_m;
            sq_a   <= sq_a >> 1;
            sq_m   <= sq_m << 1;
            step_q <= step_q + SW'(1);
          end else begin
            step_q <= '0;
            sq_acc <= '0;
            sq_a   <= nxt_op;
            sq_m   <= {{(DW-COORD_W){1'b0}}, nxt_op};
            if (last_ch) begin
              ch_q  <= '0;
              state <= (state == S_SQ_X) ? S_SQ_Y : S_LOAD;
            end else begin
              ch_q <= ch_q + IDXW'(1);
            end
          end
        end
        S_LOAD: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Increments are 2*d+1 with d sign-extended, i.e. (d+1)^2 - d^2.
  always_comb begin
    dx = '0;
    dy = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      dx = $signed({2'b00, hpos}) - $signed({2'b00, sh_cx[k*COORD_W +: COORD_W]});
      dy = $signed({2'b00, vpos}) - $signed({2'b00, sh_cy[k*COORD_W +: COORD_W]});
      col_inc[k] = {{(DW-COORD_W-1){dx[COORD_W+1]}}, dx[COORD_W:0], 1'b1};
      row_inc[k] = {{(DW-COORD_W-1){dy[COORD_W+1]}}, dy[COORD_W:0], 1'b1};
      sum[k]     = DW'(row_q[k] + col_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        col0_q[k] <= '0;
        row_q[k]  <= '0;
        col_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (sq_wb && state == S_SQ_X && ch_q == IDXW'(k)) col0_q[k] <= sq_acc;
        if (sq_wb && state == S_SQ_Y && ch_q == IDXW'(k)) row_q[k] <= {1'b0, sq_acc};
        else if (eol) row_q[k] <= row_q[k] + row_inc[k];
        if (hpos == H_LAST) col_q[k] <= {1'b0, col0_q[k]};
        else if (display_on) col_q[k] <= col_q[k] + col_inc[k];
      end
    end
  end

  // Strict less-than while scanning upward keeps ties on the lowest index.
  always_comb begin
    best_d = '1;
    best_i = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sh_en[k] && (!found || dist2[k*DW +: DW] < best_d)) begin
        found  = 1'b1;
        best_d = dist2[k*DW +: DW];
        best_i = IDXW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dist2     <= '0;
      d2_valid  <= 1'b0;
      min_d2    <= '1;
      min_idx   <= '0;
      min_valid <= 1'b0;
    end else begin
      d2_valid <= pix;
      for (int unsigned k = 0; k < N_CH; k++)
        dist2[k*DW +: DW] <= pix ? sum[k] : '0;
      min_valid <= d2_valid && found;
      min_d2    <= d2_valid ? best_d : '1;
      min_idx   <= d2_valid ? best_i : '0;
    end
  end

endmodule

// File: tb/tb_multi_ring_tracer.sv
// Bench for multi_ring_tracer: small raster, random and directed centres, checked
// every cycle against a direct (x-cx)^2+(y-cy)^2 / argmin model.
module tb_multi_ring_tracer;
  localparam int N      = 4;
  localparam int CW     = 10;
  localparam int HA     = 64;
  localparam int VA     = 40;
  localparam int HT     = 100;
  localparam int VT     = 45;
  localparam int DW     = 2 * CW + 1;
  localparam int SQ_CYC = 2 * N * (CW + 1) + 1;
  localparam longint ALL1 = (64'd1 << DW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [CW-1:0]   hpos, vpos;
  logic            display_on;
  logic [N*CW-1:0] cx_in, cy_in;
  logic [N-1:0]    ch_en;
  logic [N*DW-1:0] dist2;
  logic            d2_valid;
  logic [DW-1:0]   min_d2;
  logic [1:0]      min_idx;
  logic            min_valid, ready, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_ring_tracer #(
    .N_CH(N), .COORD_W(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .cx_in(cx_in), .cy_in(cy_in), .ch_en(ch_en), .dist2(dist2), .d2_valid(d2_valid),
    .min_d2(min_d2), .min_idx(min_idx), .min_valid(min_valid), .ready(ready), .busy(busy)
  );

  // Reference state: latched centres, readiness, and the previous cycle's distances.
  longint m_cx [N];
  longint m_cy [N];
  logic [N-1:0] m_en = '0;
  bit     m_ready = 0;
  int     bl = 0;
  bit     pv = 0;
  longint pd [N];
  int     busy_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] d2_of(input int k);
    return dist2[k*DW +: DW];
  endfunction

  task automatic set_centre(input int k, input int x, input int y);
    cx_in[k*CW +: CW] = CW'(x);
    cy_in[k*CW +: CW] = CW'(y);
  endtask

  task automatic rand_centres();
    for (int k = 0; k < N; k++)
      set_centre(k, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
  endtask

  // One clock: sample outputs for the inputs just presented, update model, advance beam.
  task automatic step();
    longint ed [N];
    bit     ev, found;
    longint best;
    int     bi;
    @(posedge clk);
    #1;
    if (reset) begin
      chk("rst_d2_valid", d2_valid, 0);
      for (int k = 0; k < N; k++) chk("rst_dist2", d2_of(k), 0);
      chk("rst_min_valid", min_valid, 0);
      chk("rst_min_d2", min_d2, ALL1);
      chk("rst_min_idx", min_idx, 0);
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 0);
      m_ready = 0; m_en = '0; bl = 0; pv = 0;
      for (int k = 0; k < N; k++) begin m_cx[k] = 0; m_cy[k] = 0; pd[k] = 0; end
    end else begin
      ev = m_ready && display_on;
      for (int k = 0; k < N; k++) begin
        longint dx = longint'(hpos) - m_cx[k];
        longint dy = longint'(vpos) - m_cy[k];
        ed[k] = ev ? dx * dx + dy * dy : 0;
      end
      chk("d2_valid", d2_valid, ev);
      for (int k = 0; k < N; k++) chk("dist2", d2_of(k), ed[k]);
      found = 0; best = ALL1; bi = 0;
      if (pv)
        for (int k = 0; k < N; k++)
          if (m_en[k] && (!found || pd[k] < best)) begin found = 1; best = pd[k]; bi = k; end
      chk("min_valid", min_valid, found);
      chk("min_d2", min_d2, best);
      chk("min_idx", min_idx, bi);
      chk("ready", ready, m_ready);
      if (hpos == 0 && vpos == VA) begin
        for (int k = 0; k < N; k++) begin
          m_cx[k] = longint'(cx_in[k*CW +: CW]);
          m_cy[k] = longint'(cy_in[k*CW +: CW]);
        end
        m_en = ch_en;
        bl = SQ_CYC;
        busy_cnt = 0;
      end
      if (bl != 0) begin
        bl--;
        if (bl == 0) m_ready = 1;
      end
      pv = ev;
      for (int k = 0; k < N; k++) pd[k] = ed[k];
    end
    if (busy) busy_cnt++;
    if (hpos == CW'(HT - 1)) begin
      hpos = '0;
      vpos = (vpos == CW'(VT - 1)) ? '0 : vpos + 1'b1;
    end else begin
      hpos = hpos + 1'b1;
    end
    display_on = (hpos < CW'(HA)) && (vpos < CW'(VA));
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(hpos == CW'(h) && vpos == CW'(v)) && n < 2 * HT * VT) begin
      step();
      n++;
    end
    chk("run_to_pos", {vpos, hpos}, {CW'(v), CW'(h)});
  endtask

  initial begin
    longint ocx, ocy;
    hpos = '0; vpos = '0; display_on = 1'b1;
    cx_in = '0; cy_in = '0; ch_en = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Single-centre style frame: channel 0 at screen centre.
    rand_centres();
    set_centre(0, 32, 20);
    ch_en = 4'b0001;
    run_to(0, 0);
    run_to(0, VA);
    run_to(0, 0);
    step();
    chk("single_origin", d2_of(0), 32 * 32 + 20 * 20);
    run_to(32, 20);
    step();
    chk("single_centre", d2_of(0), 0);
    step();
    chk("single_min_d2", min_d2, 0);
    chk("single_min_idx", min_idx, 0);
    run_to(63, 39);
    step();
    chk("single_corner", d2_of(0), 31 * 31 + 19 * 19);

    // Two centres: nearest selection and tie-break.
    set_centre(0, 10, 10);
    set_centre(1, 50, 10);
    ch_en = 4'b0011;
    run_to(0, 0);
    run_to(20, 10);
    step(); step();
    chk("two_near0_idx", min_idx, 0);
    chk("two_near0_d2", min_d2, 100);
    run_to(30, 10);
    step(); step();
    chk("two_tie_idx", min_idx, 0);
    chk("two_tie_d2", min_d2, 400);
    run_to(40, 10);
    step(); step();
    chk("two_near1_idx", min_idx, 1);
    chk("two_near1_d2", min_d2, 100);

    // Enable mask: none enabled, then only channel 2.
    rand_centres();
    ch_en = 4'b0000;
    run_to(0, 0);
    run_to(10, 5);
    step(); step();
    chk("mask_none_valid", min_valid, 0);
    rand_centres();
    ch_en = 4'b0100;
    run_to(0, 0);
    run_to(10, 19);
    step(); step();
    chk("mask_ch2_idx", min_idx, 2);
    chk("mask_ch2_valid", min_valid, 1);

    // Mid-frame change: new centres must not affect the rest of this frame.
    run_to(0, 20);
    ocx = longint'(cx_in[2*CW +: CW]);
    ocy = longint'(cy_in[2*CW +: CW]);
    rand_centres();
    set_centre(0, 0, 0);
    set_centre(3, 1023, 1023);
    ch_en = 4'b1111;
    run_to(5, 25);
    step();
    chk("midframe_old", d2_of(2), (5 - ocx) * (5 - ocx) + (25 - ocy) * (25 - ocy));

    // Corner centre, then reset mid-frame.
    run_to(0, 0);
    step();
    chk("corner_d2", d2_of(3), 2093058);
    chk("origin_d2", d2_of(0), 0);
    step();
    chk("corner_min_d2", min_d2, 0);
    chk("corner_min_idx", min_idx, 0);
    run_to(0, 30);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("post_rst_ready", ready, 0);
    run_to(0, VA + 1);
    chk("busy_cycles", busy_cnt, SQ_CYC);
    chk("ready_after_sq", ready, 1);

    // Full frames with the relatched centres, then a random configuration.
    run_to(0, 0);
    rand_centres();
    ch_en = 4'($urandom_range(1, 15));
    run_to(0, VA);
    run_to(0, 0);
    run_to(0, VA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
